// File: rtl/rsff_drv.sv
// rsff_drv: drives the S/R inputs of an external RS flip-flop with a timed
// pulse, waits through an S=R=0 hold gap, then confirms the requested state
// from the Q feedback, reporting done (and err on timeout).
// Optional feature macro: RSFF_DRV_QBAR_CHK_EN -- when defined, an illegal
// feedback pair (qbar_fb == q_fb) aborts the check with an error and blocks
// the no-pulse shortcut; when undefined, qbar_fb is ignored.
module rsff_drv #(
  parameter int PULSE_W = 2,
  parameter int HOLD_W  = 1,
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_set,
  output logic req_ready,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic S,
  output logic R,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKIP  = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  // Terminal counts: each state ends on the edge where cnt reaches its last value.
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_W - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
  localparam bit         HAS_HOLD   = (HOLD_W > 0);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       target, target_nx;
  logic       s_nx, r_nx, done_nx, err_nx;
  logic       fb_legal;

`ifdef RSFF_DRV_QBAR_CHK_EN
  // Complementary outputs are the only legal flip-flop feedback.
  assign fb_legal = (qbar_fb != q_fb);
`else
  logic unused_qbar;
  assign unused_qbar = qbar_fb;
  assign fb_legal    = 1'b1;
`endif

  // State register plus registered drive/status outputs; reset drops S/R at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      target <= 1'b0;
      S      <= 1'b0;
      R      <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      target <= target_nx;
      S      <= s_nx;
      R      <= r_nx;
      done   <= done_nx;
      err    <= err_nx;
    end
  end

  // Next-state logic: sequence accept -> pulse -> hold -> check, or shortcut via SKIP.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 8'd1;
    target_nx = target;
    s_nx      = 1'b0;
    r_nx      = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = 8'd0;
        if (req_valid) begin
          target_nx = req_set;
          if ((q_fb == req_set) && fb_legal) begin
            state_nx = SKIP;
          end else begin
            state_nx = PULSE;
            s_nx     = req_set;
            r_nx     = ~req_set;
          end
        end
      end
      SKIP: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
        done_nx  = 1'b1;
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nx = 8'd0;
          if (HAS_HOLD) begin
            state_nx = HOLD;
          end else begin
            state_nx = CHECK;
          end
        end else begin
          s_nx = S;
          r_nx = R;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx   = 8'd0;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (!fb_legal) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
        end else if (q_fb == target) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
          done_nx  = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_rsff_drv.sv
// tb_rsff_drv: randomized self-checking bench for rsff_drv. Each command gets
// a per-edge feedback script; the expected completion edge and error flag are
// derived from that script, and every cycle's S/R/done/err/ready is compared.
module tb_rsff_drv;

  localparam int PW   = 2;
  localparam int HW   = 1;
  localparam int TO   = 4;
  localparam int C0   = PW + HW + 1;
  localparam int LAST = C0 + TO - 1;
`ifdef RSFF_DRV_QBAR_CHK_EN
  localparam bit QBAR_CHK = 1'b1;
`else
  localparam bit QBAR_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic reqValid, reqSet, reqReady;
  logic qFb, qbarFb;
  logic sDrv, rDrv, busy, done, err;

  int numVectors    = 0;
  int numMiscompares = 0;

  // Feedback values seen by the DUT at edge j (relative to the accept edge 0).
  bit qv  [0:LAST+2];
  bit qbv [0:LAST+2];

  rsff_drv #(.PULSE_W(PW), .HOLD_W(HW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_set(reqSet), .req_ready(reqReady),
    .q_fb(qFb), .qbar_fb(qbarFb),
    .S(sDrv), .R(rDrv), .busy(busy), .done(done), .err(err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    numVectors++;
    if (obs !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the edge at which done rises and its err value, from the rules.
  task automatic predict(input bit set, output bit skip, output int doneOff, output bit expErr);
    skip = (qv[0] == set) && !(QBAR_CHK && (qbv[0] == qv[0]));
    if (skip) begin
      doneOff = 1;
      expErr  = 1'b0;
      return;
    end
    doneOff = LAST;
    expErr  = 1'b1;
    for (int j = C0; j <= LAST; j++) begin
      if (QBAR_CHK && (qbv[j] == qv[j])) begin
        doneOff = j;
        expErr  = 1'b1;
        return;
      end
      if (qv[j] == set) begin
        doneOff = j;
        expErr  = 1'b0;
        return;
      end
    end
  endtask

  // One command: q0 = initial Q, flip-flop follows from edge k, illegal pair from edge m (<0 none).
  task automatic applyStimulus(input bit set, input bit q0, input int k, input int m);
    bit skip;
    bit expErr;
    int doneOff;
    for (int j = 0; j <= LAST + 2; j++) begin
      qv[j]  = (j <= k) ? q0 : set;
      qbv[j] = (m >= 0 && j >= m) ? qv[j] : ~qv[j];
    end
    predict(set, skip, doneOff, expErr);
    reqValid = 1'b1;
    reqSet   = set;
    qFb      = qv[0];
    qbarFb   = qbv[0];
    @(posedge clk);
    for (int j = 0; j <= doneOff; j++) begin
      #1;
      reqValid = (j < doneOff) ? 1'($urandom_range(0, 1)) : 1'b0;
      reqSet   = 1'($urandom_range(0, 1));
      qFb      = qv[j+1];
      qbarFb   = qbv[j+1];
      @(negedge clk);
      checkOutput("S",     sDrv,  !skip && set  && (j < PW));
      checkOutput("R",     rDrv,  !skip && !set && (j < PW));
      checkOutput("SR_excl", sDrv & rDrv, 1'b0);
      checkOutput("done",  done,  j == doneOff);
      checkOutput("err",   err,   (j == doneOff) && expErr);
      checkOutput("ready", reqReady, j == doneOff);
      checkOutput("busy",  busy,  j != doneOff);
      if (j < doneOff) @(posedge clk);
    end
  endtask

  // Idle cycles with no request: controller must sit quietly.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      reqSet   = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("idle_ready", reqReady, 1'b1);
      checkOutput("idle_S", sDrv, 1'b0);
      checkOutput("idle_R", rDrv, 1'b0);
      checkOutput("idle_done", done, 1'b0);
    end
  endtask

  // Reset asserted mid-pulse: S drops at once, command abandoned, no done.
  task automatic resetDuringPulse();
    reqValid = 1'b1;
    reqSet   = 1'b1;
    qFb      = 1'b0;
    qbarFb   = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_pre_S", sDrv, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_S", sDrv, 1'b0);
    checkOutput("rst_R", rDrv, 1'b0);
    checkOutput("rst_ready", reqReady, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hold_done", done, 1'b0);
    checkOutput("rst_hold_S", sDrv, 1'b0);
    rst = 1'b0;
    idleCycles(2);
  endtask

  initial begin
    rst      = 1'b1;
    reqValid = 1'b0;
    reqSet   = 1'b0;
    qFb      = 1'b0;
    qbarFb   = 1'b1;
    #12;
    checkOutput("reset_S", sDrv, 1'b0);
    checkOutput("reset_R", rDrv, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_ready", reqReady, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] directed commands");
    applyStimulus(1'b1, 1'b0, 1, -1);
    applyStimulus(1'b0, 1'b1, 1, -1);
    idleCycles(1);
    applyStimulus(1'b1, 1'b1, 1, -1);
    applyStimulus(1'b1, 1'b0, 100, -1);
    applyStimulus(1'b1, 1'b0, 1, 3);
    applyStimulus(1'b0, 1'b1, 3, -1);
    resetDuringPulse();
    applyStimulus(1'b1, 1'b0, 1, -1);

    $display("[TB] random commands");
    for (int n = 0; n < 300; n++) begin
      bit set;
      bit q0;
      int k;
      int m;
      set = 1'($urandom_range(0, 1));
      q0  = 1'($urandom_range(0, 1));
      k   = ($urandom_range(0, 1) == 0) ? 1 : int'($urandom_range(1, LAST + 1));
      m   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAST + 1)) : -1;
      applyStimulus(set, q0, k, m);
      if ($urandom_range(0, 2) != 0) idleCycles(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
